// File: rtl/ssp_rx.sv
`default_nettype none
// ============================================================================
// Module   : ssp_rx
// Purpose  : Receive half of the Synchronous Serial Port. Oversamples the
//            serial receive clock in the PCLK domain, deserialises MSB-first
//            frames announced by frame-sync, and queues the words in a small
//            FIFO that the host drains with bus read accesses.
// Ports    : PCLK        - the only clock, rising edge
//            CLEAR       - synchronous active-high reset
//            PSEL/PWRITE - read access when PSEL=1 and PWRITE=0
//            SSPCLKIN    - serial clock, sampled as data (period 2 x PCLK)
//            SSPFSSIN    - frame sync, sampled on SSPCLKIN rising edges
//            SSPRXD      - serial data, MSB first
//            PRDATA      - last word popped from the FIFO
//            SSPRXINTR   - FIFO full
//            SSPRXEMPTY  - FIFO empty
// Revision : 1.0 - initial release
// ============================================================================
module ssp_rx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             PCLK,
    input  logic             CLEAR,
    input  logic             PSEL,
    input  logic             PWRITE,
    input  logic             SSPCLKIN,
    input  logic             SSPFSSIN,
    input  logic             SSPRXD,
    output logic [WIDTH-1:0] PRDATA,
    output logic             SSPRXINTR,
    output logic             SSPRXEMPTY
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0]  c_LAST_BIT   = c_CNT_W'(WIDTH - 1);
    localparam logic [c_ADDR_W:0]   c_FULL_COUNT = (c_ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Serial clock edge detect and receive FSM
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]    r_sr;
    logic                r_clk_q;

    logic                w_rise;
    logic [WIDTH-1:0]    w_word;
    logic                w_push;

    assign w_rise = SSPCLKIN & ~r_clk_q;
    // Word as it will look once the current bit is shifted in; on the last
    // bit this is the completed frame, pushed straight into the FIFO.
    assign w_word = {r_sr[WIDTH-2:0], SSPRXD};
    assign w_push = w_rise && (r_state == ST_SHIFT) && (r_cnt == c_LAST_BIT);

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_clk_q <= 1'b0;
        end else begin
            r_clk_q <= SSPCLKIN;
            if (w_rise) begin
                case (r_state)
                    ST_IDLE: begin
                        // Sync edge carries no data bit.
                        if (SSPFSSIN) begin
                            r_state <= ST_SHIFT;
                            r_cnt   <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        r_sr <= w_word;
                        if (r_cnt == c_LAST_BIT) begin
                            r_cnt <= '0;
                            // Sync on the last bit starts the next frame
                            // immediately; sync on any other bit is ignored.
                            r_state <= SSPFSSIN ? ST_SHIFT : ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_rp;
    logic [c_ADDR_W-1:0] r_wp;
    logic [c_ADDR_W:0]   r_count;
    logic [WIDTH-1:0]    r_prdata;

    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_wr;

    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = PSEL && !PWRITE && !w_empty;
    // A push into a full FIFO only lands if a pop frees a slot this cycle.
    assign w_wr    = w_push && (!w_full || w_pop);

    // Storage has no reset; its contents are irrelevant while count is 0.
    always_ff @(posedge PCLK) begin
        if (!CLEAR && w_wr) begin
            r_mem[r_wp] <= w_word;
        end
    end

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            r_rp     <= '0;
            r_wp     <= '0;
            r_count  <= '0;
            r_prdata <= '0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                // When full, rp==wp: the read sees the old word while the
                // simultaneous push overwrites that slot.
                r_prdata <= r_mem[r_rp];
                r_rp     <= r_rp + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign PRDATA     = r_prdata;
    assign SSPRXINTR  = w_full;
    assign SSPRXEMPTY = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_ssp_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssp_rx
// Purpose  : Directed self-checking bench for ssp_rx. Inputs change on the
//            PCLK falling edge; outputs are sampled on falling edges too.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssp_rx;

    logic       PCLK = 1'b0;
    logic       CLEAR;
    logic       PSEL;
    logic       PWRITE;
    logic       SSPCLKIN;
    logic       SSPFSSIN;
    logic       SSPRXD;
    logic [7:0] PRDATA;
    logic       SSPRXINTR;
    logic       SSPRXEMPTY;

    int total = 0;
    int bad   = 0;

    always #5 PCLK = ~PCLK;

    ssp_rx #(.WIDTH(8), .DEPTH(4)) dut (
        .PCLK       (PCLK),
        .CLEAR      (CLEAR),
        .PSEL       (PSEL),
        .PWRITE     (PWRITE),
        .SSPCLKIN   (SSPCLKIN),
        .SSPFSSIN   (SSPFSSIN),
        .SSPRXD     (SSPRXD),
        .PRDATA     (PRDATA),
        .SSPRXINTR  (SSPRXINTR),
        .SSPRXEMPTY (SSPRXEMPTY)
    );

    // One SSPCLKIN period (2 PCLK): high with fss/rxd valid, then low.
    // rd issues a read in the same PCLK cycle as the rise.
    task automatic sclk(input logic fss, input logic rxd, input logic rd);
        @(negedge PCLK);
        SSPCLKIN = 1'b1;
        SSPFSSIN = fss;
        SSPRXD   = rxd;
        PSEL     = rd;
        PWRITE   = 1'b0;
        @(negedge PCLK);
        SSPCLKIN = 1'b0;
        SSPFSSIN = 1'b0;
        PSEL     = 1'b0;
    endtask

    // Eight data bits MSB first; fss_bit (0..6) pulses sync mid-frame.
    task automatic send_bits(input logic [7:0] d, input logic last_fss,
                             input int fss_bit, input logic rd_last);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) sclk(last_fss, d[0], rd_last);
            else        sclk(k == fss_bit, d[7-k], 1'b0);
        end
    endtask

    task automatic send_frame(input logic [7:0] d);
        sclk(1'b1, 1'b0, 1'b0);
        send_bits(d, 1'b0, -1, 1'b0);
    endtask

    task automatic do_read();
        @(negedge PCLK);
        PSEL   = 1'b1;
        PWRITE = 1'b0;
        @(negedge PCLK);
        PSEL   = 1'b0;
    endtask

    task automatic test_reset();
        CLEAR = 1'b1; PSEL = 1'b0; PWRITE = 1'b0;
        SSPCLKIN = 1'b0; SSPFSSIN = 1'b0; SSPRXD = 1'b0;
        repeat (2) @(negedge PCLK);
        CLEAR = 1'b0;
        total++;
        if (PRDATA !== 8'h00 || SSPRXINTR !== 1'b0 || SSPRXEMPTY !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: got prdata=%h intr=%b empty=%b want 00 0 1",
                     PRDATA, SSPRXINTR, SSPRXEMPTY);
        end
        // Make PRDATA nonzero and leave one word queued, then clear mid-frame.
        send_frame(8'h5A);
        do_read();
        total++;
        if (PRDATA !== 8'h5A) begin
            bad++;
            $display("FAIL reset_preload: got %h want 5a", PRDATA);
        end
        send_frame(8'hC3);
        sclk(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) sclk(1'b0, 1'b1, 1'b0);
        @(negedge PCLK);
        CLEAR = 1'b1;
        repeat (2) @(negedge PCLK);
        CLEAR = 1'b0;
        total++;
        if (PRDATA !== 8'h00 || SSPRXINTR !== 1'b0 || SSPRXEMPTY !== 1'b1) begin
            bad++;
            $display("FAIL reset_midframe: got prdata=%h intr=%b empty=%b want 00 0 1",
                     PRDATA, SSPRXINTR, SSPRXEMPTY);
        end
        // Remaining bits of the cut frame must not complete a word.
        for (int k = 0; k < 5; k++) sclk(1'b0, 1'b1, 1'b0);
        total++;
        if (SSPRXEMPTY !== 1'b1) begin
            bad++;
            $display("FAIL reset_partial_lost: got empty=%b want 1", SSPRXEMPTY);
        end
    endtask

    task automatic test_single();
        logic [7:0] d;
        d = 8'hA5;
        sclk(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) sclk(1'b0, d[7-k], 1'b0);
        @(negedge PCLK);
        SSPCLKIN = 1'b1;
        SSPFSSIN = 1'b0;
        SSPRXD   = d[0];
        #1;
        total++;
        if (SSPRXEMPTY !== 1'b1) begin
            bad++;
            $display("FAIL single_empty_before: got %b want 1", SSPRXEMPTY);
        end
        @(negedge PCLK);
        SSPCLKIN = 1'b0;
        total++;
        if (SSPRXEMPTY !== 1'b0) begin
            bad++;
            $display("FAIL single_empty_after: got %b want 0", SSPRXEMPTY);
        end
        do_read();
        total++;
        if (PRDATA !== 8'hA5 || SSPRXEMPTY !== 1'b1) begin
            bad++;
            $display("FAIL single_read: got %h empty=%b want a5 1", PRDATA, SSPRXEMPTY);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4];
        exp = '{8'h01, 8'h80, 8'hFF, 8'h3C};
        sclk(1'b1, 1'b0, 1'b0);
        send_bits(exp[0], 1'b1, -1, 1'b0);
        send_bits(exp[1], 1'b1, -1, 1'b0);
        send_bits(exp[2], 1'b1, -1, 1'b0);
        send_bits(exp[3], 1'b0, -1, 1'b0);
        total++;
        if (SSPRXINTR !== 1'b1) begin
            bad++;
            $display("FAIL b2b_full: got intr=%b want 1", SSPRXINTR);
        end
        for (int i = 0; i < 4; i++) begin
            do_read();
            total++;
            if (PRDATA !== exp[i]) begin
                bad++;
                $display("FAIL b2b_read%0d: got %h want %h", i, PRDATA, exp[i]);
            end
        end
        total++;
        if (SSPRXEMPTY !== 1'b1 || SSPRXINTR !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drained: got empty=%b intr=%b want 1 0",
                     SSPRXEMPTY, SSPRXINTR);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp [4];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) send_frame(exp[i]);
        send_frame(8'h55);
        total++;
        if (SSPRXINTR !== 1'b1) begin
            bad++;
            $display("FAIL ovf_intr: got %b want 1", SSPRXINTR);
        end
        for (int i = 0; i < 4; i++) begin
            do_read();
            total++;
            if (PRDATA !== exp[i]) begin
                bad++;
                $display("FAIL ovf_read%0d: got %h want %h", i, PRDATA, exp[i]);
            end
        end
        do_read();
        total++;
        if (PRDATA !== 8'h44 || SSPRXEMPTY !== 1'b1) begin
            bad++;
            $display("FAIL ovf_fifth_read: got %h empty=%b want 44 1",
                     PRDATA, SSPRXEMPTY);
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp [4];
        exp = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
        send_frame(8'hA1);
        for (int i = 0; i < 3; i++) send_frame(exp[i]);
        sclk(1'b1, 1'b0, 1'b0);
        send_bits(8'hB5, 1'b0, -1, 1'b1);
        total++;
        if (PRDATA !== 8'hA1 || SSPRXINTR !== 1'b1) begin
            bad++;
            $display("FAIL pp_full: got %h intr=%b want a1 1", PRDATA, SSPRXINTR);
        end
        for (int i = 0; i < 4; i++) begin
            do_read();
            total++;
            if (PRDATA !== exp[i]) begin
                bad++;
                $display("FAIL pp_read%0d: got %h want %h", i, PRDATA, exp[i]);
            end
        end
        total++;
        if (SSPRXEMPTY !== 1'b1) begin
            bad++;
            $display("FAIL pp_empty: got %b want 1", SSPRXEMPTY);
        end
    endtask

    task automatic test_empty_read_sync();
        do_read();
        total++;
        if (PRDATA !== 8'hB5 || SSPRXEMPTY !== 1'b1) begin
            bad++;
            $display("FAIL empty_read: got %h empty=%b want b5 1", PRDATA, SSPRXEMPTY);
        end
        sclk(1'b1, 1'b0, 1'b0);
        send_bits(8'h96, 1'b0, 3, 1'b0);
        total++;
        if (SSPRXEMPTY !== 1'b0) begin
            bad++;
            $display("FAIL sync_word_count: got empty=%b want 0", SSPRXEMPTY);
        end
        do_read();
        total++;
        if (PRDATA !== 8'h96 || SSPRXEMPTY !== 1'b1) begin
            bad++;
            $display("FAIL sync_ignored: got %h empty=%b want 96 1", PRDATA, SSPRXEMPTY);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_empty_read_sync();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
